// File: rtl/mini_cpu_control_unit.sv
// Hardwired fetch/execute sequencer for the mini CPU datapath: one T-step per clock.
// Optional macro CTRL_ILLEGAL_TRAP_EN: jal and 11100-11111 trap to HALT with sticky illegal_op.
module mini_cpu_control_unit #(
  parameter int OP_W         = 5,
  parameter int MEM_WAIT_MAX = 0
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic [OP_W-1:0] ir_op,
  input  logic            con_ff,
  input  logic            mem_ready,
  input  logic            stop,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            InPortout,
  output logic            Cout,
  output logic            BAout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            HIin,
  output logic            LOin,
  output logic            CONin,
  output logic            OutPortin,
  output logic            Read,
  output logic            Write,
  output logic [OP_W-1:0] op,
  output logic            run,
  output logic            mem_err
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic            illegal_op
`endif
);

  typedef enum logic [3:0] {
    IDLE_RST, T0, T1, T2, T3, T4, T5, T6, T7, PAUSE, HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MD, C_NN, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
  } cls_t;

  localparam int WCW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam bit WAIT_EN = (MEM_WAIT_MAX > 0);
  localparam logic [WCW-1:0] WLAST = WCW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(3);

  state_t          state;
  state_t          last_st;
  state_t          nxt_step;
  cls_t            cls;
  logic [OP_W-1:0] imm_op;
  logic [WCW-1:0]  wait_cnt;
  logic            in_wait;

  function automatic logic in_rng(input logic [OP_W-1:0] v, input int lo, input int hi);
    return (v >= OP_W'(lo)) && (v <= OP_W'(hi));
  endfunction

  always_comb begin
    cls = C_NOP;
    if      (in_rng(ir_op, 3, 11))   cls = C_ALU;
    else if (in_rng(ir_op, 12, 14))  cls = C_IMM;
    else if (ir_op == OP_W'(0))      cls = C_LD;
    else if (ir_op == OP_W'(1))      cls = C_LDI;
    else if (ir_op == OP_W'(2))      cls = C_ST;
    else if (in_rng(ir_op, 15, 16))  cls = C_MD;
    else if (in_rng(ir_op, 17, 18))  cls = C_NN;
    else if (ir_op == OP_W'(19))     cls = C_BR;
    else if (ir_op == OP_W'(20))     cls = C_JR;
    else if (ir_op == OP_W'(22))     cls = C_IN;
    else if (ir_op == OP_W'(23))     cls = C_OUT;
    else if (ir_op == OP_W'(24))     cls = C_MFHI;
    else if (ir_op == OP_W'(25))     cls = C_MFLO;
    else if (ir_op == OP_W'(27))     cls = C_HALT;
    else if (ir_op == OP_W'(21) || in_rng(ir_op, 28, 31)) cls = C_ILL;
  end

  always_comb begin
    case (ir_op)
      OP_W'(13): imm_op = OP_W'(5);
      OP_W'(14): imm_op = OP_W'(6);
      default:   imm_op = OP_ADD;
    endcase
  end

  // Final execute step of each instruction class; the edge leaving it ends the instruction.
  always_comb begin
    case (cls)
      C_LD, C_ST:          last_st = T7;
      C_ALU, C_IMM, C_LDI: last_st = T5;
      C_MD, C_BR:          last_st = T6;
      C_NN:                last_st = T4;
      default:             last_st = T3;
    endcase
  end

  always_comb begin
    case (state)
      T0:      nxt_step = T1;
      T1:      nxt_step = T2;
      T2:      nxt_step = T3;
      T3:      nxt_step = T4;
      T4:      nxt_step = T5;
      T5:      nxt_step = T6;
      T6:      nxt_step = T7;
      default: nxt_step = T0;
    endcase
  end

  assign in_wait = (state == T1) ||
                   (state == T6 && cls == C_LD) ||
                   (state == T7 && cls == C_ST);

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state    <= IDLE_RST;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_op <= 1'b0;
`endif
    end else if (in_wait && !mem_ready) begin
      if (WAIT_EN && wait_cnt == WLAST) begin
        mem_err  <= 1'b1;
        wait_cnt <= '0;
        state    <= HALT;
      end else if (WAIT_EN) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
      case (state)
        IDLE_RST: state <= T0;
        PAUSE:    if (!stop) state <= T0;
        HALT:     state <= HALT;
        default: begin
          if (state == T3 && cls == C_HALT) state <= HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          else if (state == T3 && cls == C_ILL) begin
            state      <= HALT;
            illegal_op <= 1'b1;
          end
`endif
          else if (state == last_st) state <= stop ? PAUSE : T0;
          else state <= nxt_step;
        end
      endcase
    end
  end

  assign run = (state == T0) || (state == T1) || (state == T2) || (state == T3) ||
               (state == T4) || (state == T5) || (state == T6) || (state == T7);

  always_comb begin
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout} = '0;
    {Gra, Grb, Grc, Rin, Rout} = '0;
    {PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin} = '0;
    {Read, Write} = '0;
    op = '0;
    case (state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        case (cls)
          C_ALU, C_IMM:       begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LDI, C_LD, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_MD:               begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_NN:               begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; op = ir_op; end
          C_BR:               begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_JR:               begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_IN:               begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_OUT:              begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          C_MFHI:             begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MFLO:             begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          C_ALU:              begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; op = ir_op; end
          C_IMM:              begin Cout = 1'b1; Zin = 1'b1; op = imm_op; end
          C_LDI, C_LD, C_ST:  begin Cout = 1'b1; Zin = 1'b1; op = OP_ADD; end
          C_MD:               begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; op = ir_op; end
          C_NN:               begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_BR:               begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
          C_MD:                begin Zlowout = 1'b1; LOin = 1'b1; end
          C_BR:                begin Cout = 1'b1; Zin = 1'b1; op = OP_ADD; end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          C_LD:    begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:    begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_MD:    begin Zhighout = 1'b1; HIin = 1'b1; end
          C_BR:    begin Zlowout = 1'b1; PCin = con_ff; end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mini_cpu_control_unit.sv
// Randomized bench for mini_cpu_control_unit against a step-table model of the instruction set.
`timescale 1ns/1ps
module tb_mini_cpu_control_unit;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       clear, con_ff, mem_ready, stop;
  logic [4:0] ir_op;
  logic       mem_ready2;
  logic [26:0] v1, v2;
  logic [4:0]  op1, op2;
  logic        run1, run2, me1, me2;

  assign mem_ready2 = 1'b0;

  localparam logic [26:0] PCO  = 27'd1 << 26, ZHO  = 27'd1 << 25, ZLO  = 27'd1 << 24,
                          MDRO = 27'd1 << 23, HIO  = 27'd1 << 22, LOO  = 27'd1 << 21,
                          INO  = 27'd1 << 20, CO   = 27'd1 << 19, BAO  = 27'd1 << 18,
                          GRA  = 27'd1 << 17, GRB  = 27'd1 << 16, GRC  = 27'd1 << 15,
                          RI   = 27'd1 << 14, RO   = 27'd1 << 13, PCI  = 27'd1 << 12,
                          INC  = 27'd1 << 11, MARI = 27'd1 << 10, MDRI = 27'd1 << 9,
                          IRI  = 27'd1 << 8,  YI   = 27'd1 << 7,  ZI   = 27'd1 << 6,
                          HII  = 27'd1 << 5,  LOI  = 27'd1 << 4,  CONI = 27'd1 << 3,
                          OPI  = 27'd1 << 2,  RD   = 27'd1 << 1,  WR   = 27'd1 << 0;

  mini_cpu_control_unit #(.OP_W(5), .MEM_WAIT_MAX(0)) dut (
    .Clock(Clock), .clear(clear), .ir_op(ir_op), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
    .PCout(v1[26]), .Zhighout(v1[25]), .Zlowout(v1[24]), .MDRout(v1[23]), .HIout(v1[22]),
    .LOout(v1[21]), .InPortout(v1[20]), .Cout(v1[19]), .BAout(v1[18]), .Gra(v1[17]),
    .Grb(v1[16]), .Grc(v1[15]), .Rin(v1[14]), .Rout(v1[13]), .PCin(v1[12]), .IncPC(v1[11]),
    .MARin(v1[10]), .MDRin(v1[9]), .IRin(v1[8]), .Yin(v1[7]), .Zin(v1[6]), .HIin(v1[5]),
    .LOin(v1[4]), .CONin(v1[3]), .OutPortin(v1[2]), .Read(v1[1]), .Write(v1[0]),
    .op(op1), .run(run1), .mem_err(me1));

  mini_cpu_control_unit #(.OP_W(5), .MEM_WAIT_MAX(4)) dut_to (
    .Clock(Clock), .clear(clear), .ir_op(ir_op), .con_ff(con_ff), .mem_ready(mem_ready2), .stop(stop),
    .PCout(v2[26]), .Zhighout(v2[25]), .Zlowout(v2[24]), .MDRout(v2[23]), .HIout(v2[22]),
    .LOout(v2[21]), .InPortout(v2[20]), .Cout(v2[19]), .BAout(v2[18]), .Gra(v2[17]),
    .Grb(v2[16]), .Grc(v2[15]), .Rin(v2[14]), .Rout(v2[13]), .PCin(v2[12]), .IncPC(v2[11]),
    .MARin(v2[10]), .MDRin(v2[9]), .IRin(v2[8]), .Yin(v2[7]), .Zin(v2[6]), .HIin(v2[5]),
    .LOin(v2[4]), .CONin(v2[3]), .OutPortin(v2[2]), .Read(v2[1]), .Write(v2[0]),
    .op(op2), .run(run2), .mem_err(me2));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: instruction = list of steps ----------------
  localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_PAUSE = 2'd2, M_HALT = 2'd3;
  typedef struct packed { logic [1:0] mode; logic [3:0] idx; } mdl_t;
  mdl_t m = '0;

  function automatic int last_of(input logic [4:0] o);
    if (o <= 2 && o != 1)               return 7;
    if (o <= 14)                        return 5;
    if (o == 15 || o == 16 || o == 19)  return 6;
    if (o == 17 || o == 18)             return 4;
    return 3;
  endfunction

  function automatic bit is_wait(input logic [4:0] o, input int i);
    return (i == 1) || (o == 5'd0 && i == 6) || (o == 5'd2 && i == 7);
  endfunction

  function automatic logic [31:0] exp_step(input logic [4:0] o, input int i, input logic c);
    logic [26:0] s;
    logic [4:0]  a;
    bit alu, imm, mem, md, nn;
    s = '0; a = '0;
    alu = (o >= 3 && o <= 11); imm = (o >= 12 && o <= 14); mem = (o <= 2);
    md = (o == 15 || o == 16); nn = (o == 17 || o == 18);
    if      (i == 0) s = PCO | MARI | INC | ZI;
    else if (i == 1) s = ZLO | PCI | RD | MDRI;
    else if (i == 2) s = MDRO | IRI;
    else if (alu || imm) begin
      if (i == 3) s = GRB | RO | YI;
      else if (i == 4) begin
        s = alu ? (GRC | RO | ZI) : (CO | ZI);
        a = alu ? o : (o == 12 ? 5'd3 : (o == 13 ? 5'd5 : 5'd6));
      end else if (i == 5) s = ZLO | GRA | RI;
    end else if (mem) begin
      if (i == 3) s = GRB | BAO | YI;
      else if (i == 4) begin s = CO | ZI; a = 5'd3; end
      else if (i == 5) s = (o == 1) ? (ZLO | GRA | RI) : (ZLO | MARI);
      else if (i == 6) s = (o == 0) ? (RD | MDRI) : (GRA | RO | MDRI);
      else if (i == 7) s = (o == 0) ? (MDRO | GRA | RI) : WR;
    end else if (md) begin
      if (i == 3) s = GRA | RO | YI;
      else if (i == 4) begin s = GRB | RO | ZI; a = o; end
      else if (i == 5) s = ZLO | LOI;
      else if (i == 6) s = ZHO | HII;
    end else if (nn) begin
      if (i == 3) begin s = GRB | RO | ZI; a = o; end
      else if (i == 4) s = ZLO | GRA | RI;
    end else if (o == 19) begin
      if (i == 3) s = GRA | RO | CONI;
      else if (i == 4) s = PCO | YI;
      else if (i == 5) begin s = CO | ZI; a = 5'd3; end
      else if (i == 6) s = ZLO | (c ? PCI : 27'd0);
    end else if (i == 3) begin
      case (o)
        5'd20: s = GRA | RO | PCI;
        5'd22: s = INO | GRA | RI;
        5'd23: s = GRA | RO | OPI;
        5'd24: s = HIO | GRA | RI;
        5'd25: s = LOO | GRA | RI;
        default: s = '0;
      endcase
    end
    return {a, s};
  endfunction

  function automatic mdl_t mnext(input mdl_t s);
    mdl_t n;
    n = s;
    if (!clear) begin n.mode = M_IDLE; n.idx = 0; end
    else case (s.mode)
      M_IDLE:  begin n.mode = M_RUN; n.idx = 0; end
      M_PAUSE: if (!stop) begin n.mode = M_RUN; n.idx = 0; end
      M_HALT:  n = s;
      default: begin
        if (is_wait(ir_op, int'(s.idx)) && !mem_ready) n = s;
        else if (int'(s.idx) == last_of(ir_op)) begin
          n.idx = 0;
          if (ir_op == 5'd27) n.mode = M_HALT;
          else if (stop) n.mode = M_PAUSE;
        end else n.idx = s.idx + 4'd1;
      end
    endcase
    return n;
  endfunction

  always @(posedge Clock) m <= mnext(m);

  // ---------------- compare process ----------------
  bit chk_en = 0, rnd = 0;
  int rd6 = 0;
  logic brq[$];
  always @(negedge Clock) begin
    if (chk_en) begin
      logic [31:0] e;
      e = (m.mode == M_RUN) ? exp_step(ir_op, int'(m.idx), con_ff) : 32'd0;
      chk("strobes", 32'(v1), 32'(e[26:0]));
      chk("op", 32'(op1), 32'(e[31:27]));
      chk("run", 32'(run1), 32'(m.mode == M_RUN));
      chk("mem_err", 32'(me1), 32'd0);
      if (!rnd && m.mode == M_RUN && m.idx == 4'd6) begin
        if (ir_op == 5'd0 && v1[1]) rd6++;
        if (ir_op == 5'd19) brq.push_back(v1[12]);
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct { logic [4:0] op; logic con; int lows; int lidx; } ins_t;
  ins_t prog[$];
  ins_t cur;
  int hcnt = 0;

  task automatic drive();
    if (m.mode == M_RUN && m.idx == 4'd0) begin
      if (prog.size() > 0) cur = prog.pop_front();
      else if (rnd) begin
        cur.op = 5'($urandom_range(0, 31));
        if (cur.op == 5'd27 && $urandom_range(0, 3) != 0) cur.op = 5'd26;
        cur.con = 1'b0; cur.lows = 0; cur.lidx = 0;
      end
      ir_op = cur.op;
    end
    if (rnd) begin
      mem_ready = ($urandom_range(0, 9) < 7);
      con_ff    = 1'($urandom_range(0, 1));
      stop      = ($urandom_range(0, 9) == 0);
      if (m.mode == M_HALT) hcnt++; else hcnt = 0;
      clear = !((hcnt > 3) || ($urandom_range(0, 299) == 0));
      if (!clear) hcnt = 0;
    end else begin
      con_ff = cur.con;
      if (m.mode == M_RUN && int'(m.idx) == cur.lidx && cur.lows > 0) begin
        mem_ready = 1'b0;
        cur.lows--;
      end else mem_ready = 1'b1;
    end
  endtask

  task automatic cyc_();
    @(posedge Clock);
    #1;
    drive();
  endtask

  task automatic at_neg();
    @(negedge Clock);
  endtask

  initial begin
    clear = 1'b0; ir_op = 5'd3; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0;
    cur = '{5'd3, 1'b0, 0, 0};
    prog.push_back('{5'd3,  1'b0, 0, 0});
    prog.push_back('{5'd1,  1'b0, 0, 0});
    prog.push_back('{5'd0,  1'b0, 3, 6});
    prog.push_back('{5'd19, 1'b0, 0, 0});
    prog.push_back('{5'd19, 1'b1, 0, 0});
    prog.push_back('{5'd2,  1'b0, 2, 7});
    prog.push_back('{5'd13, 1'b0, 0, 0});
    prog.push_back('{5'd15, 1'b0, 0, 0});
    prog.push_back('{5'd17, 1'b0, 0, 0});
    prog.push_back('{5'd20, 1'b0, 0, 0});
    prog.push_back('{5'd22, 1'b0, 0, 0});
    prog.push_back('{5'd24, 1'b0, 0, 0});
    prog.push_back('{5'd26, 1'b0, 0, 0});
    prog.push_back('{5'd27, 1'b0, 0, 0});

    repeat (2) @(posedge Clock);
    at_neg();
    chk("rst_strobes", 32'(v1), 32'd0);
    chk("rst_run", 32'(run1), 32'd0);
    chk("rst_mem_err", 32'(me1), 32'd0);
    chk("rst_to_run", 32'(run2), 32'd0);
    chk("rst_to_mem_err", 32'(me2), 32'd0);
    chk_en = 1;
    clear = 1'b1;

    cyc_(); at_neg();
    chk("alu_t0", 32'(v1), 32'(PCO | MARI | INC | ZI));
    chk("alu_t0_run", 32'(run1), 32'd1);
    cyc_(); at_neg();
    chk("alu_t1", 32'(v1), 32'(ZLO | PCI | RD | MDRI));
    cyc_(); at_neg();
    chk("alu_t2", 32'(v1), 32'(MDRO | IRI));
    cyc_(); at_neg();
    chk("alu_t3", 32'(v1), 32'(GRB | RO | YI));
    cyc_(); at_neg();
    chk("alu_t4", 32'(v1), 32'(GRC | RO | ZI));
    chk("alu_t4_op", 32'(op1), 32'd3);
    chk("to_wait4_strobes", 32'(v2), 32'(ZLO | PCI | RD | MDRI));
    chk("to_wait4_mem_err", 32'(me2), 32'd0);
    cyc_(); at_neg();
    chk("alu_t5", 32'(v1), 32'(ZLO | GRA | RI));
    chk("to_mem_err", 32'(me2), 32'd1);
    chk("to_run", 32'(run2), 32'd0);
    chk("to_strobes", 32'(v2), 32'd0);
    chk("to_op", 32'(op2), 32'd0);
    cyc_(); at_neg();
    chk("alu_next_t0", 32'(v1), 32'(PCO | MARI | INC | ZI));

    for (int g = 0; g < 600 && m.mode != M_HALT; g++) cyc_();
    repeat (20) cyc_();
    at_neg();
    chk("halt_run", 32'(run1), 32'd0);
    chk("halt_strobes", 32'(v1), 32'd0);
    chk("ld_read_cycles", 32'(rd6), 32'd4);
    chk("br_count", 32'(brq.size()), 32'd2);
    if (brq.size() == 2) begin
      chk("br_pcin_con0", 32'(brq[0]), 32'd0);
      chk("br_pcin_con1", 32'(brq[1]), 32'd1);
    end

    clear = 1'b0;
    cyc_();
    clear = 1'b1;
    at_neg();
    chk("clr_strobes", 32'(v1), 32'd0);
    chk("clr_run", 32'(run1), 32'd0);
    rnd = 1;
    cyc_(); at_neg();
    chk("clr_t0", 32'(v1), 32'(PCO | MARI | INC | ZI));

    repeat (4000) cyc_();
    at_neg();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mini_cpu_control_unit.md
Name: mini_cpu_control_unit

Overview:
- Hardwired control FSM for the mini CPU datapath.
- Runs fetch (T0-T2) and per-opcode execute steps (T3-T7), one step per clock, and drives every datapath strobe the bench currently toggles by hand.
- Sits beside data_path: takes the IR opcode, the branch CON flag and a memory ready handshake; emits the bus-select, register-load, ALU op and memory strobes.

Parameters:
- OP_W, 5, opcode/ALU op width (opcode is IR[31:27]).
- MEM_WAIT_MAX, 0, maximum wait cycles on a memory step; 0 = wait forever.

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  reset, synchronous, active-low.
- ir_op  in  OP_W  IR[31:27] from data_path.
- con_ff  in  1  branchCompare result.
- mem_ready  in  1  memory completes current Read/Write this cycle.
- stop  in  1  pause request, honoured at instruction boundary.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout  out  1 each  bus source selects.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register select/enable.
- PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin  out  1 each  load enables; Zin drives both Z halves.
- Read, Write  out  1 each  memory strobes.
- op  out  OP_W  ALU operation; 0 when no ALU step.
- run  out  1  high while fetching/executing.
- mem_err  out  1  sticky, memory wait timeout.

Behaviour:
- Outputs are a pure decode of the state register plus ir_op and con_ff; state changes only on the Clock rising edge.
- Reset (clear=0 on an edge): state=IDLE_RST, all outputs 0, run=0, mem_err=0.
- Next edge after clear=1 enters T0.
- At most one bus source is high in any state.
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin; hold in T1 until mem_ready=1.
  - T2: MDRout IRin.
- Execute from T3 by ir_op (codes as in the ISA):
  - ALU reg (00011-01011): T3 Grb Rout Yin; T4 Grc Rout Zin op=ir_op; T5 Zlowout Gra Rin.
  - addi/andi/ori (01100-01110): T3 Grb Rout Yin; T4 Cout Zin op=00011/00101/00110; T5 Zlowout Gra Rin.
  - ldi (00001): T3 Grb BAout Yin; T4 Cout Zin op=00011; T5 Zlowout Gra Rin.
  - ld (00000): T3-T4 as ldi; T5 Zlowout MARin; T6 Read MDRin, hold until mem_ready; T7 MDRout Gra Rin.
  - st (00010): T3-T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write, hold until mem_ready.
  - mul/div (01111/10000): T3 Gra Rout Yin; T4 Grb Rout Zin op=ir_op; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg/not (10001/10010): T3 Grb Rout Zin op=ir_op; T4 Zlowout Gra Rin.
  - br (10011): T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin op=00011; T6 Zlowout, PCin=con_ff.
  - jr (10100): T3 Gra Rout PCin. jal (10101): T3 Grb... not supported; treated as nop.
  - in (10110): T3 InPortout Gra Rin. out (10111): T3 Gra Rout OutPortin.
  - mfhi (11000): T3 HIout Gra Rin. mflo (11001): T3 LOout Gra Rin.
  - nop (11010) and 11100-11111: T3 no strobes.
  - halt (11011): T3 then HALT; HALT stays until reset, run=0, all strobes 0.
- End of sequence: return to T0; if stop=1 on that edge go to PAUSE instead (run=0). PAUSE returns to T0 on the first edge with stop=0.
- mem_ready is sampled only in wait states. A wait state lasts 1 + (cycles mem_ready stays low).
- MEM_WAIT_MAX>0: after MEM_WAIT_MAX low cycles, set mem_err, drop strobes, go to HALT.
- clear=0 in any state, including mid-wait, forces IDLE_RST on that edge.

Optional Feature:
- CTRL_ILLEGAL_TRAP_EN defined: opcodes 11100-11111 and 10101 go from T3 to HALT and set sticky output illegal_op=1 (port present only with the macro).
- Undefined: these opcodes behave as nop.

Test Plan:
- Reset then mem_ready=1, ir_op=00011 → states T0,T1,T2,T3,T4,T5,T0. T4 op=00011 with Grc Rout Zin; T5 Gra Rin Zlowout; 6 cycles per instruction.
- ldi with mem_ready=1 → T3 Grb BAout Yin; T4 Cout Zin op=00011; T5 Gra Rin; no Read after T1.
- ld with mem_ready held low 3 cycles in T6 → Read/MDRin high for 4 cycles, then T7 MDRout Gra Rin.
- br, con_ff=0 then con_ff=1 → T6 PCin=0 in the first run, PCin=1 in the second.
- halt → run falls after T3, all strobes 0 for 20 cycles. clear=0 one cycle → IDLE_RST, then T0.
- MEM_WAIT_MAX=4, mem_ready=0 forever in T1 → mem_err=1 after 4 wait cycles, HALT, Read=0.
